// File: rtl/complex_mult.sv
// Pipelined Q1.14 complex multiplier: product = multiplicant * W8^tw_sel.
// Two register stages: partial products, then sum/round/saturate.
module complex_mult #(
  parameter int DW      = 16,
  parameter int TW_FRAC = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [1:0]        tw_sel,
  input  logic [2*DW-1:0]   multiplicant,
  output logic              out_valid,
  output logic [2*DW-1:0]   product
);

  // Round half toward +inf at TW_FRAC, then clamp into the signed 16-bit range.
  function automatic logic [15:0] round_sat(input logic signed [32:0] sum);
    logic signed [33:0] biased;
    logic signed [33:0] shifted;
    biased  = {sum[32], sum} + 34'sd8192;
    shifted = biased >>> TW_FRAC;
    if (shifted > 34'sd32767) begin
      return 16'h7FFF;
    end else if (shifted < -34'sd32768) begin
      return 16'h8000;
    end else begin
      return shifted[15:0];
    end
  endfunction

  logic signed [15:0] a_s, b_s, c_s, d_s;
  logic signed [31:0] ac_s, bd_s, ad_s, bc_s;
  logic signed [31:0] ac_r, bd_r, ad_r, bc_r;
  logic               valid_r;
  logic signed [32:0] sum_re_s, sum_im_s;

  assign a_s = multiplicant[31:16];
  assign b_s = multiplicant[15:0];

  // Twiddle ROM: W8^k = c + jd in Q1.14.
  always_comb begin
    c_s = 16'sd16384;
    d_s = 16'sd0;
    case (tw_sel)
      2'd0: begin c_s = 16'sd16384;  d_s = 16'sd0;      end
      2'd1: begin c_s = 16'sd11585;  d_s = -16'sd11585; end
      2'd2: begin c_s = 16'sd0;      d_s = -16'sd16384; end
      2'd3: begin c_s = -16'sd11585; d_s = -16'sd11585; end
      default: begin c_s = 16'sd16384; d_s = 16'sd0;    end
    endcase
  end

  // Full-precision partial products.
  always_comb begin
    ac_s = 32'(a_s) * 32'(c_s);
    bd_s = 32'(b_s) * 32'(d_s);
    ad_s = 32'(a_s) * 32'(d_s);
    bc_s = 32'(b_s) * 32'(c_s);
  end

  // Stage 1: register partial products; data loads only on valid to cut toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac_r    <= 32'sd0;
      bd_r    <= 32'sd0;
      ad_r    <= 32'sd0;
      bc_r    <= 32'sd0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= in_valid;
      if (in_valid) begin
        ac_r <= ac_s;
        bd_r <= bd_s;
        ad_r <= ad_s;
        bc_r <= bc_s;
      end
    end
  end

  // 33-bit sums cannot overflow for any 16x16 input.
  always_comb begin
    sum_re_s = {ac_r[31], ac_r} - {bd_r[31], bd_r};
    sum_im_s = {ad_r[31], ad_r} + {bc_r[31], bc_r};
  end

  // Stage 2: round, saturate and register the packed result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product   <= 32'd0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= valid_r;
      if (valid_r) begin
        product <= {round_sat(sum_re_s), round_sat(sum_im_s)};
      end
    end
  end

endmodule

// File: tb/tb_complex_mult.sv
// Directed-vector bench for complex_mult with an arithmetic reference model
// and literal checks on key vectors.
module tb_complex_mult;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  tw_sel = 2'd0;
  logic [31:0] multiplicant = 32'd0;
  logic        out_valid;
  logic [31:0] product;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        v;
    logic [31:0] p;
  } ent_t;

  ent_t q[$];

  complex_mult dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .tw_sel       (tw_sel),
    .multiplicant (multiplicant),
    .out_valid    (out_valid),
    .product      (product)
  );

  always #5 clk = ~clk;

  function automatic longint clamp16(input longint x);
    if (x > 32767) return 32767;
    else if (x < -32768) return -32768;
    else return x;
  endfunction

  // Reference: (a+jb)(c+jd) with round-half-up at 2^-14 and saturation.
  function automatic logic [31:0] model(input logic [1:0] k, input logic [31:0] d);
    longint a, b, c, s, re, im;
    a = longint'($signed(d[31:16]));
    b = longint'($signed(d[15:0]));
    case (k)
      2'd0: begin c = 16384;  s = 0;      end
      2'd1: begin c = 11585;  s = -11585; end
      2'd2: begin c = 0;      s = -16384; end
      default: begin c = -11585; s = -11585; end
    endcase
    re = clamp16((a * c - b * s + 8192) >>> 14);
    im = clamp16((a * s + b * c + 8192) >>> 14);
    return {re[15:0], im[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Record what each sampled input must produce two edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      q.push_back({in_valid, model(tw_sel, multiplicant)});
      if (q.size() > 2) q.pop_front();
    end
  end

  // Compare process: every falling edge out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() < 2) begin
        check("out_valid_startup", {31'd0, out_valid}, 32'd0);
      end else begin
        check("out_valid", {31'd0, out_valid}, {31'd0, q[0].v});
        if (q[0].v) check("product_model", product, q[0].p);
      end
    end
  end

  task automatic drv(input logic v, input logic [1:0] k, input logic [31:0] d);
    in_valid     = v;
    tw_sel       = k;
    multiplicant = d;
    @(negedge clk);
  endtask

  logic [31:0] vecs [8] = '{32'h7FFF_7FFF, 32'h8000_7FFF, 32'h1234_ABCD, 32'hFFFF_0001,
                            32'h0001_FFFF, 32'h4000_C000, 32'h0000_0000, 32'hC350_3CB0};

  initial begin
    // Reset state
    #12;
    check("reset_product", product, 32'd0);
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drv(1'b0, 2'd0, 32'd0);

    // Identity twiddle, three back-to-back samples
    drv(1'b1, 2'd0, 32'd1200);
    drv(1'b1, 2'd0, 32'd4500);
    check("id_0", product, 32'd1200);
    drv(1'b1, 2'd0, 32'd100);
    check("id_1", product, 32'd4500);
    drv(1'b0, 2'd0, 32'd0);
    check("id_2", product, 32'd100);
    check("id_2_valid", {31'd0, out_valid}, 32'd1);
    drv(1'b0, 2'd0, 32'd0);
    check("id_end_valid", {31'd0, out_valid}, 32'd0);

    // -j twiddle, k=1 rounding, saturation, no spurious saturation
    drv(1'b1, 2'd2, 32'd1200);
    drv(1'b0, 2'd0, 32'd0);
    check("minus_j", product, 32'd78643200);
    drv(1'b1, 2'd1, 32'd1200);
    drv(1'b0, 2'd0, 32'd0);
    check("k1_round", product, 32'd55640913);
    drv(1'b1, 2'd3, 32'h8000_8000);
    drv(1'b0, 2'd0, 32'd0);
    check("k3_sat", product, 32'h0000_7FFF);
    drv(1'b1, 2'd0, 32'h8000_0000);
    drv(1'b0, 2'd0, 32'd0);
    check("k0_min", product, 32'h8000_0000);

    // Async reset with samples in flight
    drv(1'b1, 2'd1, 32'h1111_2222);
    drv(1'b1, 2'd2, 32'h3333_4444);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_product", product, 32'd0);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drv(1'b0, 2'd0, 32'd0);
    drv(1'b0, 2'd0, 32'd0);
    check("postrst_valid", {31'd0, out_valid}, 32'd0);
    drv(1'b1, 2'd0, 32'h0005_0007);
    drv(1'b0, 2'd0, 32'd0);
    check("postrst_product", product, 32'h0005_0007);
    check("postrst_lat_valid", {31'd0, out_valid}, 32'd1);

    // Valid gaps 1,0,1,1
    drv(1'b1, 2'd1, 32'h0100_0200);
    drv(1'b0, 2'd2, 32'hDEAD_BEEF);
    drv(1'b1, 2'd3, 32'hFF00_0300);
    drv(1'b1, 2'd2, 32'h7FFF_8000);
    drv(1'b0, 2'd0, 32'd0);
    drv(1'b0, 2'd0, 32'd0);

    // Mixed data across all twiddles, back to back
    for (int i = 0; i < 8; i++) drv(1'b1, 2'(i % 4), vecs[i]);
    for (int i = 0; i < 8; i++) drv(1'b1, 2'((i + 1) % 4), vecs[i]);
    drv(1'b0, 2'd0, 32'd0);
    drv(1'b0, 2'd0, 32'd0);
    drv(1'b0, 2'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/complex_mult.md
Name: complex_mult

Overview:
- Pipelined signed fixed-point complex multiplier for the FFT butterfly datapath.
- Multiplies a packed complex sample by a twiddle factor W8^k selected from an internal 4-entry ROM.
- Returns a packed complex product in the sample's format.
- Sits between the butterfly add/sub stage and the next FFT stage; accepts one sample per clock.

Parameters:
- DW, 16, width of each real/imag half (fixed at 16 for this block; total word 2*DW = 32).
- TW_FRAC, 14, fraction bits of twiddle coefficients (Q1.14, so +1.0 = 16384).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  multiplicant/tw_sel are valid this cycle.
- tw_sel  input  2  twiddle index k, W = W8^k.
- multiplicant  input  32  [31:16] real part a, [15:0] imag part b; both signed two's complement.
- out_valid  output  1  product is valid this cycle.
- product  output  32  [31:16] real result, [15:0] imag result; both signed.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - rst_n low asynchronously clears every pipeline register; product=0, out_valid=0 while in reset.
  - The first valid output follows in_valid sampled after reset release.
  - Reset asserted mid-operation discards all in-flight samples.
- Twiddle ROM, W = c + jd in Q1.14 signed 16-bit:
  - k=0: c=16384, d=0
  - k=1: c=11585, d=-11585
  - k=2: c=0, d=-16384
  - k=3: c=-11585, d=-11585
- Arithmetic:
  - re = a*c - b*d; im = a*d + b*c.
  - Each product is a full 32-bit signed value; each sum is a 33-bit signed value (no intermediate overflow).
  - Rounding: add 2^(TW_FRAC-1) = 8192, then arithmetic shift right by 14 (round half toward +inf).
  - Saturation: clamp each rounded result to [-32768, 32767] independently.
- Pipeline, latency 2:
  - Edge N: in_valid, tw_sel and multiplicant are sampled; the four partial products are registered along with a valid bit.
  - Edge N+1: sum, round and saturate; register product and out_valid.
  - product/out_valid are stable after edge N+1, i.e. 2 cycles after the inputs are presented.
- Throughput and valid handling:
  - Fully pipelined, one sample per cycle; back-to-back valids produce back-to-back outputs in order.
  - No backpressure.
  - When in_valid=0, out_valid goes 0 two cycles later.
  - product may hold don't-care data when out_valid=0; the implementation holds the last value (registers load only on valid) to cut toggling.
- Purely registered outputs; no combinational path from inputs to outputs.

Test Plan:
- Identity twiddle: tw_sel=0; multiplicant 1200, then 4500, then 100 on consecutive valid cycles -> product 1200, 4500, 100 on three consecutive cycles starting 2 cycles after the first; out_valid high for exactly 3 cycles.
- -j twiddle: tw_sel=2, multiplicant=1200 (re=0, im=1200) -> product = 1200<<16 = 78643200.
- Rounding at k=1: tw_sel=1, multiplicant=1200 -> re=849, im=849, product=55640913.
- Saturation: tw_sel=3, multiplicant=0x80008000 (a=b=-32768) -> re=0, im saturates to 32767; product=0x00007FFF. Also tw_sel=0 with a=-32768, b=0 -> product=0x80000000 (no spurious saturation).
- Reset: assert rst_n low asynchronously with valid samples in flight -> product=0 and out_valid=0 immediately, no stale output after release; a new sample after release appears with 2-cycle latency.
- Valid gaps: pattern in_valid=1,0,1,1 with distinct data -> out_valid=1,0,1,1 delayed by 2 cycles, data matching a software model of the arithmetic above.
